// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Power-up and lock-loss reset sequencer for the rPLL that turns the 27 MHz
// board oscillator into the 108 MHz video/system clock. Runs entirely on the
// 27 MHz reference (the same net as the PLL clkin), pulses the PLL reset,
// qualifies the PLL lock output and releases a clean system reset only after
// lock has been continuously high for LOCK_STABLE_CYCLES + HOLD_CYCLES.
// Any loss of lock while running re-asserts sys_reset and sets a sticky flag.
// The 108 MHz domain is expected to synchronise sys_reset locally.
//
// Sequence: PLL_RST -> WAIT_LOCK -> STABLE -> HOLD -> RUN
//   A low synchronised lock in STABLE, HOLD or RUN drops back to WAIT_LOCK.
//
// Optional feature (macro PLL_LOCK_RETRY_EN):
//   defined   : WAIT_LOCK times out after LOCK_TIMEOUT_CYCLES without lock,
//               re-enters PLL_RST to re-pulse the PLL, and retry_count
//               increments (saturating at 15).
//   undefined : WAIT_LOCK waits forever with the counter held at zero and
//               retry_count is tied to zero.
//
// Ports:
//   clk         in   27 MHz reference clock
//   reset       in   synchronous, active-high; restarts the whole sequence
//   lock        in   PLL lock, asynchronous to clk
//   clear_lost  in   clears lock_lost on the next edge (a new loss wins)
//   pll_reset   out  registered, to the PLL reset input, active-high
//   sys_reset   out  registered system reset, active-high
//   lock_lost   out  sticky: lock dropped while in RUN
//   retry_count out  saturating number of lock-timeout retries
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 2700,
  parameter int HOLD_CYCLES         = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock,
  input  logic       clear_lost,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter serves every timed state, so it is sized for the longest
  // interval any parameter can describe.
  localparam int MAX_CYCLES = max_int(max_int(max_int(SYNC_STAGES, PLL_RST_CYCLES),
                                              max_int(LOCK_STABLE_CYCLES, HOLD_CYCLES)),
                                      LOCK_TIMEOUT_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
`ifdef PLL_LOCK_RETRY_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   lost_set;
`ifdef PLL_LOCK_RETRY_EN
  logic                   timeout;
`endif

  // ---- lock synchroniser: raw lock -> lock_s --------------------------------
  // lock is asynchronous; every decision below looks only at lock_s.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_sync <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], lock};
    end
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];

  // ---- next-state and counter decode ----------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    lost_set  = 1'b0;
`ifdef PLL_LOCK_RETRY_EN
    timeout   = 1'b0;
`endif

    case (state)
      ST_PLL_RST: begin
        if (cnt == PLL_RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = ST_STABLE;
`ifdef PLL_LOCK_RETRY_EN
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_PLL_RST;
          timeout   = 1'b1;
        end
`else
        end else begin
          // Without the retry feature there is nothing to time here.
          cnt_nxt = '0;
        end
`endif
      end

      ST_STABLE: begin
        // Loss of lock outranks reaching the end of the stability window.
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        // Nothing is timed while running; park the counter.
        cnt_nxt = '0;
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          lost_set  = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_PLL_RST;
      end
    endcase

    // Every state starts its own interval from zero.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end
  end

  // ---- state, counter and registered outputs --------------------------------
  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_PLL_RST;
      cnt       <= '0;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pll_reset <= (state_nxt == ST_PLL_RST);
      sys_reset <= (state_nxt != ST_RUN);
      // A loss on the same edge as a clear request keeps the flag set.
      if (lost_set) begin
        lock_lost <= 1'b1;
      end else if (clear_lost) begin
        lock_lost <= 1'b0;
      end
    end
  end

  // ---- retry counter ---------------------------------------------------------
`ifdef PLL_LOCK_RETRY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      retry_count <= 4'd0;
    end else if (timeout && (retry_count != 4'hF)) begin
      retry_count <= retry_count + 4'd1;
    end
  end
`else
  assign retry_count = 4'd0;
`endif

endmodule
